window_buffer_gen: RTL
======================

Name: window_buffer_gen

Overview:
- Parametrised successor to the current K=3/2/5 SRAM-plus-line-buffer front end. Turns a raster stream of multi-channel pixels into KER_SIZE x KER_SIZE sliding windows for the conv datapath.
- Adds support for any kernel size, 2-D stride (x and y), valid/ready backpressure on both sides, frame-height tracking and an end-of-frame marker.
- Sits between the input pixel stream and the MAC array.

Parameters:
- KER_SIZE, 3, window edge length (>=2)
- BITWIDTH, 8, bits per pixel per channel
- NFMAPS, 3, channels per pixel
- NW, 32, image width in pixels (>= KER_SIZE)
- NH, 32, image height in rows (>= KER_SIZE)
- STRIDE_X, 1, horizontal window stride (>=1)
- STRIDE_Y, 1, vertical window stride (>=1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the current frame
- in_valid  in  1  D is valid
- in_ready  out  1  block accepts D this cycle
- D  in  NFMAPS*BITWIDTH  pixel; channel j at bits [j*BITWIDTH +: BITWIDTH]
- out_valid  out  1  Q holds a window
- out_ready  in  1  consumer takes Q
- Q  out  NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH  window
- out_last  out  1  Q is the final window of the frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: in_ready=1 (comb), out_valid=0, out_last=0, Q=0, frame_done=0. Counters, window registers and line memories are cleared.
- Accept: a pixel is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (single output register; pass-through allowed).
- Storage: KER_SIZE-1 line memories of NW entries x NFMAPS*BITWIDTH bits, register arrays with combinational read. Plus a KER_SIZE x KER_SIZE window register per channel.
- On accept at (row r, col c):
  - read column c of all line memories;
  - shift the window left one column;
  - insert the new column {lines oldest..newest, D};
  - write line memory k[c] <= line memory k+1[c], and the newest line memory [c] <= D.
- Window validity: the window is complete iff r >= KER_SIZE-1, c >= KER_SIZE-1, (r-KER_SIZE+1) % STRIDE_Y == 0 and (c-KER_SIZE+1) % STRIDE_X == 0. Implement the modulo tests with stride counters, not dividers.
- Latency: a complete window loads the output register on the accepting edge, so out_valid is high the next cycle. out_valid holds until out_ready; Q is stable while out_valid && !out_ready.
- Q packing: channel j occupies [j*K*K*BITWIDTH +: K*K*BITWIDTH]. Element (ky,kx) sits at index ky*K+kx; ky=0 is the oldest row, kx=0 is the oldest column.
- Counters: col_cnt wraps NW-1 -> 0 and increments row_cnt. row_cnt wraps NH-1 -> 0. On that wrap frame_done pulses the next cycle and the stride counters reset. The x stride counter also resets at every row wrap.
- out_last: set with the window at the last valid (r,c) position of the frame.
- Rows crossing the left edge: window columns from the previous row are never emitted, because the validity rule requires c >= KER_SIZE-1.
- flush (has priority over accept in the same cycle): clears counters, stride counters, out_valid and out_last. Line memory contents are don't-care. The pixel offered that cycle is not accepted (in_ready forced 0 while flush is high).
- Reset mid-frame: identical to power-up.
- Widths: counters are $clog2(NW) and $clog2(NH) bits; stride counters are $clog2(STRIDE)+1 bits.

Decomposition:
- Package window_buffer_pkg holds:
  - localparams PIX_W = NFMAPS*BITWIDTH and WIN_W = KER_SIZE*KER_SIZE*BITWIDTH;
  - a pixel_t typedef;
  - a function for the Q index.
- One sub-module, line_mem_bank: KER_SIZE-1 line memories with shared column address and cascade write.
- Counters, stride logic, window shift and output register stay in the top level.

Test Plan:
- K=3, NW=8, NH=6, strides 1; pixel value = r*8+c, always ready:
  - first out_valid the cycle after the 19th accepted pixel (r=2,c=2), with ch0 Q = {0,1,2,8,9,10,16,17,18} at indices 0..8;
  - 24 windows total, out_last on (5,7);
  - frame_done pulses once.
- Same stream with STRIDE_X=2, STRIDE_Y=2: exactly 6 windows, at (r,c) in {2,4} x {2,4,6}; top-left elements are 0, 2, 4, 16, 18, 20.
- Backpressure: out_ready=0 for 5 cycles at the first window. in_ready drops, Q stays {0,1,2,8,...}, no pixel is lost, and the window sequence is identical to the previous run.
- flush asserted at (3,5) together with in_valid: that pixel is not accepted and out_valid=0 next cycle. A following fresh frame gives its first window after 19 accepts.
- rstn pulsed low mid-frame: all outputs 0 asynchronously; the next frame behaves as in scenario 1.
- K=5, NFMAPS=2, NW=NH=7: 9 windows; channel 1 carries value+100 and is checked at its packed position.

Source files
------------

// File: rtl/window_buffer_pkg.sv
// ============================================================================
// window_buffer_pkg : shared defaults, pixel type and Q packing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package window_buffer_pkg;

    localparam int DEF_KER_SIZE = 3;
    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_NFMAPS   = 3;

    localparam int PIX_W = DEF_NFMAPS * DEF_BITWIDTH;
    localparam int WIN_W = DEF_KER_SIZE * DEF_KER_SIZE * DEF_BITWIDTH;

    typedef logic [PIX_W-1:0] pixel_t;

    // LSB of element (ky,kx) of channel ch inside the packed window
    function automatic int q_lsb(input int ch, input int ky, input int kx,
                                 input int k, input int bw);
        return ch * k * k * bw + (ky * k + kx) * bw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_mem_bank.sv
// ============================================================================
// line_mem_bank : cascaded line memories, shared column address, comb read
// Rev 1.0
// ============================================================================
`default_nettype none

module line_mem_bank
    import window_buffer_pkg::*;
#(
    parameter int NLINES   = DEF_KER_SIZE - 1,
    parameter int NW       = 32,
    parameter int PIX_BITS = PIX_W,
    localparam int AW      = $clog2(NW)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             we_i,
    input  logic [AW-1:0]                    addr_i,
    input  logic [PIX_BITS-1:0]              din_i,
    output logic [NLINES-1:0][PIX_BITS-1:0]  rd_o
);

    logic [PIX_BITS-1:0] mem_q [NLINES][NW];

    // Line 0 is the oldest row; each write ages the column by one line
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < NLINES; l++) begin
                for (int a = 0; a < NW; a++) begin
                    mem_q[l][a] <= '0;
                end
            end
        end else if (we_i) begin
            for (int l = 0; l < NLINES - 1; l++) begin
                mem_q[l][addr_i] <= mem_q[l+1][addr_i];
            end
            mem_q[NLINES-1][addr_i] <= din_i;
        end
    end

    generate
        for (genvar l = 0; l < NLINES; l++) begin : g_rd
            assign rd_o[l] = mem_q[l][addr_i];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/window_buffer_gen.sv
// ============================================================================
// window_buffer_gen : raster pixel stream to strided KxK sliding windows
// Rev 1.0
// ============================================================================
`default_nettype none

module window_buffer_gen
    import window_buffer_pkg::*;
#(
    parameter int KER_SIZE = DEF_KER_SIZE,
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int NFMAPS   = DEF_NFMAPS,
    parameter int NW       = 32,
    parameter int NH       = 32,
    parameter int STRIDE_X = 1,
    parameter int STRIDE_Y = 1
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      flush,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NFMAPS*BITWIDTH-1:0]                D,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH-1:0] Q,
    output logic                                      out_last,
    output logic                                      frame_done
);

    localparam int PIX_BITS = NFMAPS * BITWIDTH;
    localparam int QW       = NFMAPS * KER_SIZE * KER_SIZE * BITWIDTH;
    localparam int CW       = $clog2(NW);
    localparam int RW       = $clog2(NH);
    localparam int SXW      = $clog2(STRIDE_X) + 1;
    localparam int SYW      = $clog2(STRIDE_Y) + 1;
    localparam int LAST_R   = KER_SIZE - 1 + ((NH - KER_SIZE) / STRIDE_Y) * STRIDE_Y;
    localparam int LAST_C   = KER_SIZE - 1 + ((NW - KER_SIZE) / STRIDE_X) * STRIDE_X;

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [SXW-1:0] sx_q, sx_d;
    logic [SYW-1:0] sy_q, sy_d;
    logic [PIX_BITS-1:0] win_q [KER_SIZE][KER_SIZE];
    logic [PIX_BITS-1:0] win_d [KER_SIZE][KER_SIZE];
    logic [KER_SIZE-2:0][PIX_BITS-1:0] line_rd;
    logic [QW-1:0]  q_pack, q_q;
    logic           out_valid_q, out_last_q, frame_done_q;
    logic           accept, col_end, row_end, win_ok;

    assign in_ready   = !flush && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign col_end    = (col_q == CW'(NW - 1));
    assign row_end    = (row_q == RW'(NH - 1));
    assign win_ok     = (row_q >= RW'(KER_SIZE - 1)) && (col_q >= CW'(KER_SIZE - 1)) &&
                        (sx_q == '0) && (sy_q == '0);
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign Q          = q_q;
    assign frame_done = frame_done_q;

    line_mem_bank #(
        .NLINES   (KER_SIZE - 1),
        .NW       (NW),
        .PIX_BITS (PIX_BITS)
    ) u_lines (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (accept),
        .addr_i (col_q),
        .din_i  (D),
        .rd_o   (line_rd)
    );

    // Stride phases only advance once the window can be complete in that axis
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                sx_d  = '0;
                if (row_end) begin
                    row_d = '0;
                    sy_d  = '0;
                end else begin
                    row_d = row_q + RW'(1);
                    if (row_q >= RW'(KER_SIZE - 1)) begin
                        sy_d = (sy_q == SYW'(STRIDE_Y - 1)) ? '0 : sy_q + SYW'(1);
                    end
                end
            end else begin
                col_d = col_q + CW'(1);
                if (col_q >= CW'(KER_SIZE - 1)) begin
                    sx_d = (sx_q == SXW'(STRIDE_X - 1)) ? '0 : sx_q + SXW'(1);
                end
            end
        end
    end

    always_comb begin
        win_d = win_q;
        for (int ky = 0; ky < KER_SIZE; ky++) begin
            for (int kx = 0; kx < KER_SIZE - 1; kx++) begin
                win_d[ky][kx] = win_q[ky][kx+1];
            end
        end
        for (int ky = 0; ky < KER_SIZE - 1; ky++) begin
            win_d[ky][KER_SIZE-1] = line_rd[ky];
        end
        win_d[KER_SIZE-1][KER_SIZE-1] = D;
    end

    always_comb begin
        q_pack = '0;
        for (int ch = 0; ch < NFMAPS; ch++) begin
            for (int ky = 0; ky < KER_SIZE; ky++) begin
                for (int kx = 0; kx < KER_SIZE; kx++) begin
                    q_pack[q_lsb(ch, ky, kx, KER_SIZE, BITWIDTH) +: BITWIDTH] =
                        win_d[ky][kx][ch*BITWIDTH +: BITWIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            q_q          <= '0;
            for (int ky = 0; ky < KER_SIZE; ky++) begin
                for (int kx = 0; kx < KER_SIZE; kx++) begin
                    win_q[ky][kx] <= '0;
                end
            end
        end else if (flush) begin
            col_q        <= '0;
            row_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            frame_done_q <= accept && col_end && row_end;
            if (accept) begin
                win_q <= win_d;
            end
            if (accept && win_ok) begin
                out_valid_q <= 1'b1;
                q_q         <= q_pack;
                out_last_q  <= (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
